id_ctrl_reg: RTL
================

# id_ctrl_reg

Registered, parametrised control unit for the ID→EX boundary of the ARM pipeline. It decodes `mode`/`opcode`/`s` into the execute command and the memory/writeback/branch/status-write control bundle, and gates that bundle on the ARM condition field. It also squashes a configurable number of instructions in a taken branch's shadow and honours hazard-unit stall and flush. The bundle is held in a pipeline register with a valid/ready handshake.

## Interface
Parameters:
- `MODE_LEN`, 2: mode field width.
- `OPCODE_LEN`, 4: opcode field width.
- `EXE_CMD_LEN`, 4: execute command width (≥4; commands zero-extended).
- `BRANCH_SHADOW`, 1: younger accepted instructions squashed after a taken branch (0..7).

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `in_valid` in 1: decode-stage instruction valid.
- `in_ready` out 1: equals `!stall`.
- `mode` in `MODE_LEN`: 00 arithmetic, 01 memory, 10 branch, 11 reserved.
- `opcode` in `OPCODE_LEN`: data-processing opcode.
- `s` in 1: S bit (memory: 1 = LDR, 0 = STR).
- `cond` in 4: ARM condition field.
- `flags` in 4: current status {N,Z,C,V}.
- `stall` in 1: hold the output register; accept nothing.
- `flush` in 1: clear the output register and shadow state.
- `out_valid` out 1: the output register holds a live instruction.
- `exe_cmd` out `EXE_CMD_LEN`: ALU command.
- `mem_read`, `mem_write`, `wb_enable`, `branch_taken`, `status_write_enable` out 1 each.

## Operation
- Accept when `in_valid && in_ready && !flush`.
- Decode for arithmetic mode. Each entry is opcode → exe_cmd, wb, swe:
  - MOV 1101→0001, wb=1, swe=s
  - MVN 1111→1001, wb=1, swe=s
  - ADD 0100→0010, wb=1, swe=s
  - ADC 0101→0011, wb=1, swe=s
  - SUB 0010→0100, wb=1, swe=s
  - SBC 0110→0101, wb=1, swe=s
  - AND 0000→0110, wb=1, swe=s
  - ORR 1100→0111, wb=1, swe=s
  - EOR 0001→1000, wb=1, swe=s
  - CMP 1010→0100, wb=0, swe=1
  - TST 1000→0110, wb=0, swe=1
  - Any other opcode gives all zeros.
- Decode for memory mode:
  - LDR: exe_cmd=0010, mem_read=1, wb=1, swe=0.
  - STR: exe_cmd=0010, mem_write=1, all others 0.
- Decode for branch mode: `branch_taken`=1, all others 0.
- Mode 11 decodes to all zeros.
- Condition check against `flags`, standard ARM table 0000 EQ .. 1110 AL. 1111 is treated as fail.
- A condition fail loads a bubble: `out_valid`=0 and all controls 0.
- State machine:
  - States are RUN and SHADOW, with a 3-bit counter `sh_cnt`.
  - RUN: accepting a taken branch (condition pass) with `BRANCH_SHADOW`>0 sets `sh_cnt`=`BRANCH_SHADOW` and moves to SHADOW.
  - SHADOW: each accepted instruction loads a bubble and decrements `sh_cnt`. The accept that reaches 0 returns the block to RUN.
  - Cycles with no accept leave `sh_cnt` unchanged.
  - A branch that is squashed in the shadow does not restart the counter.
  - With `BRANCH_SHADOW`=0, SHADOW is never entered.
- Priority: `rst` > `flush` > `stall` > accept > idle.
  - flush: output register becomes a bubble, state becomes RUN, `sh_cnt`=0.
  - stall: output register and state are held.
  - idle (`in_valid`=0, no stall): output register becomes a bubble.

## Timing
- Latency: 1 cycle from accept edge to registered outputs.
- All outputs are registered except `in_ready`, which is combinational from `stall`.
- Reset values: `out_valid`=0, `exe_cmd`=0, all control bits 0, state RUN, `sh_cnt`=0.
  - Since `in_ready` is combinational from `stall`, its value during reset equals `!stall`.
- Reset mid-shadow aborts squashing.
- `stall` and `flush` asserted together: flush wins.
- `flush` in the same cycle as a branch accept: the branch is discarded and no shadow is entered.
- Condition uses `flags` sampled in the accept cycle. There is no forwarding of flags from the in-flight instruction; that is the hazard unit's job.

## Configuration
- Macro `ID_CTRL_COND_EXEC_EN`.
- Defined: the condition check above is applied.
- Undefined: `cond` and `flags` are ignored, and every instruction behaves as AL.

## Test plan
- Reset, then ADD with s=1, cond=1110 → next cycle: `out_valid`=1, exe_cmd=0010, wb=1, swe=1, all other controls 0.
- CMP with cond=0000 and flags=0100 (Z=1) → exe_cmd=0100, wb=0, swe=1. The same instruction with flags=0000 → bubble, `out_valid`=0.
- LDR with `stall`=1 for 3 cycles, then `stall`=0 → `in_ready`=0 and the previous bundle is held for 3 cycles. LDR then appears one cycle after the stall drops: mem_read=1, wb=1, exe_cmd=0010.
- `BRANCH_SHADOW`=2: branch AL followed by ADD, SUB, MOV → outputs are branch_taken=1, bubble, bubble, then MOV with exe_cmd=0001.
- Flush asserted while in SHADOW with `sh_cnt`=1, then ADD → bubble for the flush cycle, then ADD is live with exe_cmd=0010.
- `rst` pulsed while `out_valid`=1 with a STR bundle → all outputs 0 on the next edge. With the macro undefined, an ADD with cond=0000 and Z=0 is still live.

Source files
------------

// File: rtl/id_ctrl_reg_if.sv
// ID->EX control register bus: decode inputs, hazard controls
// and the registered execute/memory/writeback control bundle.
interface id_ctrl_reg_if #(
  parameter int MODE_LEN    = 2,
  parameter int OPCODE_LEN  = 4,
  parameter int EXE_CMD_LEN = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [MODE_LEN-1:0]    mode;
  logic [OPCODE_LEN-1:0]  opcode;
  logic                   s;
  logic [3:0]             cond;
  logic [3:0]             flags;
  logic                   stall;
  logic                   flush;
  logic                   out_valid;
  logic [EXE_CMD_LEN-1:0] exe_cmd;
  logic                   mem_read;
  logic                   mem_write;
  logic                   wb_enable;
  logic                   branch_taken;
  logic                   status_write_enable;

  modport master (
    output in_valid, mode, opcode, s, cond, flags, stall, flush,
    input  in_ready, out_valid, exe_cmd, mem_read, mem_write,
    input  wb_enable, branch_taken, status_write_enable
  );

  modport slave (
    input  in_valid, mode, opcode, s, cond, flags, stall, flush,
    output in_ready, out_valid, exe_cmd, mem_read, mem_write,
    output wb_enable, branch_taken, status_write_enable
  );
endinterface

// File: rtl/id_ctrl_reg.sv
// ID->EX control decode register with condition gating and branch shadow.
// Macro ID_CTRL_COND_EXEC_EN enables the ARM condition check on cond/flags.
module id_ctrl_reg #(
  parameter int MODE_LEN      = 2,
  parameter int OPCODE_LEN    = 4,
  parameter int EXE_CMD_LEN   = 4,
  parameter int BRANCH_SHADOW = 1
) (
  input logic         clk,
  input logic         rst,
  id_ctrl_reg_if.slave bus
);
  typedef enum logic {RUN, SHADOW} state_e;

  localparam logic [2:0] SH_INIT = 3'(BRANCH_SHADOW);

  logic [1:0] md;
  logic [3:0] op;
  logic [3:0] dec_cmd;
  logic       dec_mr, dec_mw, dec_wb, dec_bt, dec_swe;
  logic       cond_ok;
  logic       live;
  logic       hold;

  state_e                 state_q, state_d;
  logic [2:0]             sh_cnt_q, sh_cnt_d;
  logic                   valid_q, valid_d;
  logic [EXE_CMD_LEN-1:0] cmd_q, cmd_d;
  logic                   mr_q, mr_d;
  logic                   mw_q, mw_d;
  logic                   wb_q, wb_d;
  logic                   bt_q, bt_d;
  logic                   swe_q, swe_d;

  assign md = 2'(bus.mode);
  assign op = 4'(bus.opcode);

  // Decode mode/opcode/s into the raw control bundle
  always_comb begin
    dec_cmd = 4'b0000;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_wb  = 1'b0;
    dec_bt  = 1'b0;
    dec_swe = 1'b0;
    case (md)
      2'b00: begin
        dec_wb  = 1'b1;
        dec_swe = bus.s;
        case (op)
          4'b1101: dec_cmd = 4'b0001;
          4'b1111: dec_cmd = 4'b1001;
          4'b0100: dec_cmd = 4'b0010;
          4'b0101: dec_cmd = 4'b0011;
          4'b0010: dec_cmd = 4'b0100;
          4'b0110: dec_cmd = 4'b0101;
          4'b0000: dec_cmd = 4'b0110;
          4'b1100: dec_cmd = 4'b0111;
          4'b0001: dec_cmd = 4'b1000;
          4'b1010: begin
            dec_cmd = 4'b0100;
            dec_wb  = 1'b0;
            dec_swe = 1'b1;
          end
          4'b1000: begin
            dec_cmd = 4'b0110;
            dec_wb  = 1'b0;
            dec_swe = 1'b1;
          end
          default: begin
            dec_wb  = 1'b0;
            dec_swe = 1'b0;
          end
        endcase
      end
      2'b01: begin
        dec_cmd = 4'b0010;
        dec_mr  = bus.s;
        dec_wb  = bus.s;
        dec_mw  = !bus.s;
      end
      2'b10:   dec_bt = 1'b1;
      default: ;
    endcase
  end

`ifdef ID_CTRL_COND_EXEC_EN
  // ARM condition table against {N,Z,C,V}; 1111 never passes
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = bus.flags;
    case (bus.cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = !z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = !c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = !n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = !v;
      4'b1000: cond_ok = c && !z;
      4'b1001: cond_ok = !c || z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = !z && (n == v);
      4'b1101: cond_ok = z || (n != v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^{bus.cond, bus.flags};
  assign cond_ok     = 1'b1;
`endif

  assign bus.in_ready = !bus.stall;
  assign hold = !bus.flush && bus.stall;
  assign live = !bus.flush && !bus.stall && bus.in_valid
             && cond_ok && (state_q == RUN);

  // Output bundle: hold on stall, load when live, otherwise bubble
  always_comb begin
    valid_d = 1'b0;
    cmd_d   = '0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    wb_d    = 1'b0;
    bt_d    = 1'b0;
    swe_d   = 1'b0;
    if (hold) begin
      valid_d = valid_q;
      cmd_d   = cmd_q;
      mr_d    = mr_q;
      mw_d    = mw_q;
      wb_d    = wb_q;
      bt_d    = bt_q;
      swe_d   = swe_q;
    end else if (live) begin
      valid_d = 1'b1;
      cmd_d   = EXE_CMD_LEN'(dec_cmd);
      mr_d    = dec_mr;
      mw_d    = dec_mw;
      wb_d    = dec_wb;
      bt_d    = dec_bt;
      swe_d   = dec_swe;
    end
  end

  // Branch shadow sequencing: count accepted instructions to squash
  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    if (bus.flush) begin
      state_d  = RUN;
      sh_cnt_d = 3'd0;
    end else if (!bus.stall && bus.in_valid) begin
      if (state_q == SHADOW) begin
        sh_cnt_d = sh_cnt_q - 3'd1;
        if (sh_cnt_q == 3'd1) state_d = RUN;
      end else if (cond_ok && dec_bt && SH_INIT != 3'd0) begin
        state_d  = SHADOW;
        sh_cnt_d = SH_INIT;
      end
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      sh_cnt_q <= 3'd0;
      valid_q  <= 1'b0;
      cmd_q    <= '0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      wb_q     <= 1'b0;
      bt_q     <= 1'b0;
      swe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      valid_q  <= valid_d;
      cmd_q    <= cmd_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      wb_q     <= wb_d;
      bt_q     <= bt_d;
      swe_q    <= swe_d;
    end
  end

  assign bus.out_valid           = valid_q;
  assign bus.exe_cmd             = cmd_q;
  assign bus.mem_read            = mr_q;
  assign bus.mem_write           = mw_q;
  assign bus.wb_enable           = wb_q;
  assign bus.branch_taken        = bt_q;
  assign bus.status_write_enable = swe_q;
endmodule
